// File: rtl/span_pkg.sv
// span_pkg -- shared types and helpers for the span_phase_multi meter.
//   span_state_e : measurement FSM states (IDLE, ARM, MEASURE, DONE)
//   SPAN_CW, SPAN_SYNC_STAGES : default counter width / synchroniser depth
//   sat_inc()    : saturating increment for counters up to 64 bits wide
package span_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE
  } span_state_e;

  localparam int unsigned SPAN_CW          = 32;
  localparam int unsigned SPAN_SYNC_STAGES = 2;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/span_sync.sv
// span_sync -- multi-bit synchroniser with per-bit rising-edge detect.
// Every bit goes through the same number of flops, so bits sampled together
// stay aligned (zero inter-bit skew).
// Ports:
//   clk     in  sampling clock
//   rst     in  synchronous active-high reset
//   i_d     in  W asynchronous inputs
//   o_q     out W synchronised inputs
//   o_rise  out W one-cycle rising-edge flags (o_q & ~previous o_q)
module span_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  // Fewer than two flops gives no metastability protection.
  localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [W-1:0] r_pipe [DEPTH];
  logic [W-1:0] r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        r_pipe[s] <= '0;
      end
      r_last <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
      r_last <= r_pipe[DEPTH-1];
    end
  end

  assign o_q    = r_pipe[DEPTH-1];
  assign o_rise = r_pipe[DEPTH-1] & ~r_last;

endmodule

// File: rtl/span_phase_multi.sv
// span_phase_multi -- N-channel equal-precision time-interval / phase meter.
// Over a window of whole reference periods (opened and closed by synchronised
// sig_ref rising edges) each channel counts base-clock ticks where it equals
// the reference (cnt_same) and where it differs (cnt_diff), and reports
// whether it was high at the closing reference edge (lead).
// Optional build macro: SPAN_TIMEOUT_EN adds a watchdog that ends ARM/MEASURE
// after TIMEOUT_CYCLES clocks without a reference edge (timeout=1, counts 0).
// Ports:
//   clk_base      in   base/count clock, posedge
//   rst           in   synchronous active-high reset
//   start         in   one-cycle pulse, begin a measurement (ignored if busy)
//   abort         in   one-cycle pulse, cancel measurement (beats start)
//   gate_periods  in   window length in reference periods (0 -> 1)
//   sig_ref       in   asynchronous reference
//   sig_ch        in   N_CH asynchronous test signals
//   busy          out  high in ARM and MEASURE
//   done          out  one-cycle pulse while new results are presented
//   timeout       out  last measurement ended by watchdog
//   cnt_same      out  per channel ch==ref ticks, channel k at [k*CW +: CW]
//   cnt_diff      out  per channel ch!=ref ticks
//   cnt_ref       out  reference periods counted
//   lead          out  channel high at the closing reference edge
//   ovf           out  a counter of the channel saturated
module span_phase_multi
  import span_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned CW             = SPAN_CW,
  parameter int unsigned SYNC_STAGES    = SPAN_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic                 clk_base,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          gate_periods,
  input  logic                 sig_ref,
  input  logic [N_CH-1:0]      sig_ch,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [N_CH*CW-1:0]   cnt_same,
  output logic [N_CH*CW-1:0]   cnt_diff,
  output logic [CW-1:0]        cnt_ref,
  output logic [N_CH-1:0]      lead,
  output logic [N_CH-1:0]      ovf
);

  // Common width for comparing the reference counter with the 16-bit gate.
  localparam int unsigned XW = (CW > 16) ? CW : 16;

  span_state_e r_state;
  span_state_e w_next;

  logic [N_CH:0]    w_sync_q;
  logic [N_CH:0]    w_sync_rise;
  logic             w_ref_s;
  logic             w_ref_rise;
  logic [N_CH-1:0]  w_ch_s;
  logic             w_unused_rise;

  logic [CW-1:0]    r_same [N_CH];
  logic [CW-1:0]    r_diff [N_CH];
  logic [CW-1:0]    r_ref;
  logic [15:0]      r_gate;
  logic [N_CH-1:0]  r_ovf;

  logic [N_CH*CW-1:0] r_cnt_same;
  logic [N_CH*CW-1:0] r_cnt_diff;
  logic [CW-1:0]      r_cnt_ref;
  logic [N_CH-1:0]    r_lead;
  logic [N_CH-1:0]    r_ovf_o;
  logic               r_timeout;

  logic [CW-1:0]    w_ref_inc;
  logic             w_close;
  logic             w_wd_hit;
  logic             w_arm_entry;
  logic             w_count;
  logic             w_ref_tick;
  logic             w_finish;

  // Reference and channels share one synchroniser so they stay aligned.
  span_sync #(
    .W      (N_CH + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk_base),
    .rst    (rst),
    .i_d    ({sig_ch, sig_ref}),
    .o_q    (w_sync_q),
    .o_rise (w_sync_rise)
  );

  assign w_ref_s       = w_sync_q[0];
  assign w_ch_s        = w_sync_q[N_CH:1];
  assign w_ref_rise    = w_sync_rise[0];
  assign w_unused_rise = ^w_sync_rise[N_CH:1];

  assign busy = (r_state == ST_ARM) || (r_state == ST_MEASURE);
  assign done = (r_state == ST_DONE);

  assign w_ref_inc = CW'(sat_inc(64'(r_ref), CW));
  // Closing edge: this reference edge brings the period count to the gate.
  assign w_close   = (r_state == ST_MEASURE) && w_ref_rise &&
                     (XW'(w_ref_inc) == XW'(r_gate));

`ifdef SPAN_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd;

  always_ff @(posedge clk_base) begin
    if (rst || w_arm_entry) begin
      r_wd <= '0;
    end else if (busy) begin
      r_wd <= w_ref_rise ? '0 : r_wd + WDW'(1);
    end
  end

  assign w_wd_hit = busy && !w_ref_rise && (r_wd == WDW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_wd_hit         = 1'b0;
`endif

  always_ff @(posedge clk_base) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) w_next = ST_ARM;
      end
      ST_ARM: begin
        if (abort)           w_next = ST_IDLE;
        else if (w_wd_hit)   w_next = ST_DONE;
        else if (w_ref_rise) w_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (abort)           w_next = ST_IDLE;
        else if (w_close)    w_next = ST_DONE;
        else if (w_wd_hit)   w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_arm_entry = (r_state == ST_IDLE) && (w_next == ST_ARM);
  // The opening edge (seen in ARM) is the first counted tick; the closing
  // edge tick is excluded.
  assign w_count     = ((r_state == ST_ARM) && w_ref_rise) ||
                       ((r_state == ST_MEASURE) && !w_close);
  assign w_ref_tick  = (r_state == ST_MEASURE) && w_ref_rise;
  assign w_finish    = (w_next == ST_DONE);

  always_ff @(posedge clk_base) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        r_same[k] <= '0;
        r_diff[k] <= '0;
      end
      r_ref  <= '0;
      r_ovf  <= '0;
      r_gate <= '0;
    end else if (w_arm_entry) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        r_same[k] <= '0;
        r_diff[k] <= '0;
      end
      r_ref  <= '0;
      r_ovf  <= '0;
      r_gate <= (gate_periods == 16'd0) ? 16'd1 : gate_periods;
    end else begin
      if (w_count) begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          if (w_ch_s[k] == w_ref_s) begin
            r_same[k] <= CW'(sat_inc(64'(r_same[k]), CW));
            if (r_same[k] == '1) r_ovf[k] <= 1'b1;
          end else begin
            r_diff[k] <= CW'(sat_inc(64'(r_diff[k]), CW));
            if (r_diff[k] == '1) r_ovf[k] <= 1'b1;
          end
        end
      end
      if (w_ref_tick) begin
        r_ref <= w_ref_inc;
        if (r_ref == '1) r_ovf <= '1;
      end
    end
  end

  // Results are registered on the transition into DONE so they are valid in
  // the same cycle done is high; the closing edge's period increment, lead
  // sample and reference overflow are folded in here directly.
  always_ff @(posedge clk_base) begin
    if (rst) begin
      r_cnt_same <= '0;
      r_cnt_diff <= '0;
      r_cnt_ref  <= '0;
      r_lead     <= '0;
      r_ovf_o    <= '0;
      r_timeout  <= 1'b0;
    end else if (w_finish) begin
      if (w_close) begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          r_cnt_same[k*CW +: CW] <= r_same[k];
          r_cnt_diff[k*CW +: CW] <= r_diff[k];
        end
        r_cnt_ref <= w_ref_inc;
        r_lead    <= w_ch_s;
        r_ovf_o   <= r_ovf | {N_CH{r_ref == '1}};
        r_timeout <= 1'b0;
      end else begin
        r_cnt_same <= '0;
        r_cnt_diff <= '0;
        r_cnt_ref  <= '0;
        r_lead     <= '0;
        r_ovf_o    <= '0;
        r_timeout  <= 1'b1;
      end
    end
  end

  assign cnt_same = r_cnt_same;
  assign cnt_diff = r_cnt_diff;
  assign cnt_ref  = r_cnt_ref;
  assign lead     = r_lead;
  assign ovf      = r_ovf_o;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_span_phase_multi.sv
// tb_span_phase_multi -- directed, table-driven bench for span_phase_multi.
// Reference period 100 clocks, 50% duty. ch0 lags by 25, ch1 leads by 25,
// ch2 = ref, ch3 = ~ref. A second instance with CW=8 sees ch = ref on every
// channel to exercise saturation.
module tb_span_phase_multi;

  logic        clk_base = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] gate_periods;
  logic        sig_ref;
  logic [3:0]  sig_ch;
  logic [3:0]  sig_ch8;

  logic         busy, done, timeout;
  logic [127:0] cnt_same, cnt_diff;
  logic [31:0]  cnt_ref;
  logic [3:0]   lead, ovf;

  logic         busy8, done8, timeout8;
  logic [31:0]  cnt_same8, cnt_diff8;
  logic [7:0]   cnt_ref8;
  logic [3:0]   lead8, ovf8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          ref_en;
  int unsigned ph;

  always #5 clk_base = ~clk_base;

  assign sig_ch8 = {4{sig_ref}};

  span_phase_multi #(
    .N_CH(4), .CW(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)
  ) u_dut (
    .clk_base(clk_base), .rst(rst), .start(start), .abort(abort),
    .gate_periods(gate_periods), .sig_ref(sig_ref), .sig_ch(sig_ch),
    .busy(busy), .done(done), .timeout(timeout),
    .cnt_same(cnt_same), .cnt_diff(cnt_diff), .cnt_ref(cnt_ref),
    .lead(lead), .ovf(ovf)
  );

  span_phase_multi #(
    .N_CH(4), .CW(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)
  ) u_dut8 (
    .clk_base(clk_base), .rst(rst), .start(start), .abort(abort),
    .gate_periods(gate_periods), .sig_ref(sig_ref), .sig_ch(sig_ch8),
    .busy(busy8), .done(done8), .timeout(timeout8),
    .cnt_same(cnt_same8), .cnt_diff(cnt_diff8), .cnt_ref(cnt_ref8),
    .lead(lead8), .ovf(ovf8)
  );

  // Signal generator, updated on the falling edge.
  initial begin
    ph      = 0;
    sig_ref = 1'b0;
    sig_ch  = 4'b0000;
    forever begin
      @(negedge clk_base);
      ph        = (ph + 1) % 100;
      sig_ref   = ref_en && (ph < 50);
      sig_ch[0] = (ph >= 25) && (ph < 75);
      sig_ch[1] = (ph >= 75) || (ph < 25);
      sig_ch[2] = sig_ref;
      sig_ch[3] = ~sig_ref;
    end
  end

  typedef struct packed {
    logic [15:0]      gate;
    logic [31:0]      ref_n;
    logic [3:0][31:0] same;
    logic [3:0][31:0] diff;
    logic [3:0]       lead;
    logic [7:0]       same8;
    logic [3:0]       ovf8;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] g, input logic [31:0] r,
                              input logic [31:0] s0, s1, s2, s3,
                              input logic [31:0] d0, d1, d2, d3,
                              input logic [7:0] s8, input logic [3:0] o8);
    vec_t v;
    v.gate  = g;
    v.ref_n = r;
    v.same  = {s3, s2, s1, s0};
    v.diff  = {d3, d2, d1, d0};
    v.lead  = 4'b0110;
    v.same8 = s8;
    v.ovf8  = o8;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] g);
    @(negedge clk_base);
    gate_periods = g;
    start        = 1'b1;
    @(negedge clk_base);
    start        = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin
        seen   = 1'b1;
        cycles = n;
        break;
      end
      @(negedge clk_base);
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk_base);
      if (done || busy) hits++;
    end
    chk(name, hits, 0);
  endtask

  vec_t vecs[5];
  bit   seen;
  int   cyc;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = mk(16'd4, 4, 200, 200, 400, 0, 200, 200, 0, 400, 8'd255, 4'hF);
    vecs[1] = mk(16'd0, 1, 50, 50, 100, 0, 50, 50, 0, 100, 8'd100, 4'h0);
    vecs[2] = mk(16'd1, 1, 50, 50, 100, 0, 50, 50, 0, 100, 8'd100, 4'h0);
    vecs[3] = mk(16'd2, 2, 100, 100, 200, 0, 100, 100, 0, 200, 8'd200, 4'h0);
    vecs[4] = mk(16'd3, 3, 150, 150, 300, 0, 150, 150, 0, 300, 8'd255, 4'hF);

    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_periods = '0; ref_en = 1'b1;
    repeat (5) @(negedge clk_base);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt_ref", cnt_ref, 0);
    chk("rst_cnt_same", (cnt_same == '0), 1);
    chk("rst_cnt_diff", (cnt_diff == '0), 1);
    chk("rst_lead", lead, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk_base);

    for (int i = 0; i < 5; i++) begin
      pulse_start(vecs[i].gate);
      chk("busy_after_start", busy, 1);
      wait_done(seen, cyc);
      chk("done_seen", seen, 1);
      if (seen) begin
        chk("cnt_ref", cnt_ref, vecs[i].ref_n);
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("same%0d_g%0d", k, vecs[i].gate), cnt_same[k*32 +: 32], vecs[i].same[k]);
          chk($sformatf("diff%0d_g%0d", k, vecs[i].gate), cnt_diff[k*32 +: 32], vecs[i].diff[k]);
        end
        chk("lead", lead, vecs[i].lead);
        chk("ovf", ovf, 0);
        chk("timeout_clear", timeout, 0);
        chk("busy_in_done", busy, 0);
        chk("done8_aligned", done8, 1);
        chk("cnt_ref8", cnt_ref8, vecs[i].ref_n);
        chk("same8_ch0", cnt_same8[7:0], vecs[i].same8);
        chk("same8_ch3", cnt_same8[31:24], vecs[i].same8);
        chk("diff8_ch0", cnt_diff8[7:0], 0);
        chk("ovf8", ovf8, vecs[i].ovf8);
        chk("lead8", lead8, 4'hF);
      end
      @(negedge clk_base);
      chk("done_one_pulse", done, 0);
      chk("busy_after_done", busy, 0);
    end

    // Abort mid-measurement: no done, previous (gate 3) results kept.
    pulse_start(16'd4);
    repeat (200) @(negedge clk_base);
    chk("busy_before_abort", busy, 1);
    abort = 1'b1;
    @(negedge clk_base);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    watch_quiet("abort_no_done", 600);
    chk("abort_cnt_ref_kept", cnt_ref, 3);
    chk("abort_same0_kept", cnt_same[31:0], 150);

    // Start while busy is ignored: window stays at 2 periods.
    pulse_start(16'd2);
    repeat (150) @(negedge clk_base);
    pulse_start(16'd4);
    wait_done(seen, cyc);
    chk("busy_start_done", seen, 1);
    chk("busy_start_cnt_ref", cnt_ref, 2);
    chk("busy_start_same0", cnt_same[31:0], 100);
    chk("busy_start_diff0", cnt_diff[31:0], 100);
    @(negedge clk_base);

    // start and abort together in IDLE: nothing happens.
    @(negedge clk_base);
    start = 1'b1; abort = 1'b1; gate_periods = 16'd1;
    @(negedge clk_base);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    watch_quiet("start_abort_quiet", 600);
    chk("start_abort_cnt_ref", cnt_ref, 2);

    // Reset mid-window clears everything, no done afterwards.
    pulse_start(16'd4);
    repeat (200) @(negedge clk_base);
    rst = 1'b1;
    repeat (2) @(negedge clk_base);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt_ref", cnt_ref, 0);
    chk("midrst_same0", cnt_same[31:0], 0);
    chk("midrst_diff1", cnt_diff[63:32], 0);
    chk("midrst_lead", lead, 0);
    chk("midrst_same8", cnt_same8, 0);
    watch_quiet("midrst_quiet", 500);

    // Recovery after reset.
    pulse_start(16'd1);
    wait_done(seen, cyc);
    chk("recover_done", seen, 1);
    chk("recover_cnt_ref", cnt_ref, 1);
    chk("recover_same0", cnt_same[31:0], 50);
    chk("recover_diff3", cnt_diff[127:96], 100);
    @(negedge clk_base);

`ifdef SPAN_TIMEOUT_EN
    ref_en = 1'b0;
    repeat (20) @(negedge clk_base);
    pulse_start(16'd4);
    wait_done(seen, cyc);
    chk("wd_done", seen, 1);
    chk("wd_latency", cyc, 1000);
    chk("wd_timeout", timeout, 1);
    chk("wd_cnt_ref", cnt_ref, 0);
    chk("wd_same0", cnt_same[31:0], 0);
    chk("wd_diff3", cnt_diff[127:96], 0);
    chk("wd_lead", lead, 0);
    chk("wd_ovf", ovf, 0);
    @(negedge clk_base);
    ref_en = 1'b1;
    repeat (200) @(negedge clk_base);
    pulse_start(16'd1);
    wait_done(seen, cyc);
    chk("wd_clear_done", seen, 1);
    chk("wd_clear_timeout", timeout, 0);
    chk("wd_clear_cnt_ref", cnt_ref, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
